cond_exec_ctrl: RTL and testbench

Execute-stage conditional-execution controller for the 5-stage ARM pipeline. It holds the architectural NZCV flag register and evaluates each Execute-stage instruction's condition field against it. It gates that instruction's register, memory and PC writes, and sequences the wrong-path annul window after a taken PC write. Saturating execute/skip counters are exposed for performance monitoring.

---
 rtl/cond_exec_ctrl.sv | 132 +++++++++++++
 tb/tb_cond_exec_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_ctrl.sv
// Execute-stage conditional-execution controller: NZCV flag register, condition
// evaluation, write gating, wrong-path annul window and saturating perf counters.
module cond_exec_ctrl #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_e,
  input  logic        stall_e,
  input  logic [3:0]  cond_e,
  input  logic [3:0]  alu_flags,
  input  logic [1:0]  flag_write_e,
  input  logic        reg_write_e,
  input  logic        mem_write_e,
  input  logic        pc_src_e,
  input  logic        cnt_clr,
  output logic        reg_write,
  output logic        mem_write,
  output logic        pc_src,
  output logic        cond_ex,
  output logic        flush_fd,
  output logic        annul,
  output logic [3:0]  flags,
  output logic [15:0] exec_cnt,
  output logic [15:0] skip_cnt
);

  typedef enum logic {RUN = 1'b0, ANNUL = 1'b1} state_t;

  localparam logic [1:0] ACNT_INIT = 2'(FLUSH_DEPTH - 1);

  state_t      state_q, state_d;
  logic [1:0]  acnt_q, acnt_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] exec_q, exec_d;
  logic [15:0] skip_q, skip_d;

  logic n, z, c, v;
  logic satisfied;
  logic live;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    satisfied = 1'b0;
    case (cond_e)
      4'b0000: satisfied = z;
      4'b0001: satisfied = ~z;
      4'b0010: satisfied = c;
      4'b0011: satisfied = ~c;
      4'b0100: satisfied = n;
      4'b0101: satisfied = ~n;
      4'b0110: satisfied = v;
      4'b0111: satisfied = ~v;
      4'b1000: satisfied = c & ~z;
      4'b1001: satisfied = ~c | z;
      4'b1010: satisfied = (n == v);
      4'b1011: satisfied = (n != v);
      4'b1100: satisfied = ~z & (n == v);
      4'b1101: satisfied = z | (n != v);
      4'b1110: satisfied = 1'b1;
      default: satisfied = 1'b0;
    endcase
  end

  // Reset also kills the live term so nothing is gated through while it is held.
  assign annul     = (state_q == ANNUL);
  assign live      = valid_e & ~stall_e & ~annul & ~reset;
  assign cond_ex   = live & satisfied;
  assign reg_write = cond_ex & reg_write_e;
  assign mem_write = cond_ex & mem_write_e;
  assign pc_src    = cond_ex & pc_src_e;
  assign flush_fd  = pc_src;
  assign flags     = flags_q;
  assign exec_cnt  = exec_q;
  assign skip_cnt  = skip_q;

  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    case (state_q)
      RUN: begin
        if (pc_src) begin
          state_d = ANNUL;
          acnt_d  = ACNT_INIT;
        end
      end
      ANNUL: begin
        if (!stall_e) begin
          if (acnt_q == 2'd0) state_d = RUN;
          else                acnt_d  = acnt_q - 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (cond_ex && flag_write_e[1]) flags_d[3:2] = alu_flags[3:2];
    if (cond_ex && flag_write_e[0]) flags_d[1:0] = alu_flags[1:0];
  end

  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (cnt_clr) begin
      exec_d = 16'h0000;
      skip_d = 16'h0000;
    end else begin
      if (cond_ex && exec_q != 16'hFFFF)                 exec_d = exec_q + 16'd1;
      if (live && !satisfied && skip_q != 16'hFFFF)      skip_d = skip_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      acnt_q  <= 2'd0;
      flags_q <= 4'b0000;
      exec_q  <= 16'h0000;
      skip_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      flags_q <= flags_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl: a vector table for condition/flag/counter
// behaviour plus hand sequences for the annul window, reset and saturation.
module tb_cond_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_e, stall_e;
  logic [3:0]  cond_e, alu_flags;
  logic [1:0]  flag_write_e;
  logic        reg_write_e, mem_write_e, pc_src_e, cnt_clr;
  logic        reg_write, mem_write, pc_src, cond_ex, flush_fd, annul;
  logic [3:0]  flags;
  logic [15:0] exec_cnt, skip_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cond_exec_ctrl #(.FLUSH_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e),
    .cond_e(cond_e), .alu_flags(alu_flags), .flag_write_e(flag_write_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .pc_src_e(pc_src_e),
    .cnt_clr(cnt_clr), .reg_write(reg_write), .mem_write(mem_write),
    .pc_src(pc_src), .cond_ex(cond_ex), .flush_fd(flush_fd), .annul(annul),
    .flags(flags), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
  );

  typedef struct {
    logic        valid, stall;
    logic [3:0]  cond, alu;
    logic [1:0]  fw;
    logic        rw, mw, ps, clr;
    logic        e_cx, e_rw, e_mw, e_ps, e_annul;
    logic [3:0]  e_flags;
    logic [15:0] e_exec, e_skip;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic valid, input logic stall, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [1:0] fw, input logic rw,
                       input logic mw, input logic ps, input logic clr);
    valid_e = valid; stall_e = stall; cond_e = cond; alu_flags = alu;
    flag_write_e = fw; reg_write_e = rw; mem_write_e = mw; pc_src_e = ps; cnt_clr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid stall cond alu fw rw mw ps clr | cx rw mw ps annul | flags exec skip
    vecs[0]  = '{1,0,4'hE,4'h4,2'b11,0,0,0,0, 1,0,0,0,0, 4'h0,16'd0,16'd0};
    vecs[1]  = '{1,0,4'h0,4'h0,2'b00,1,0,0,0, 1,1,0,0,0, 4'h4,16'd1,16'd0};
    vecs[2]  = '{1,0,4'h1,4'h0,2'b00,1,0,0,0, 0,0,0,0,0, 4'h4,16'd2,16'd0};
    vecs[3]  = '{1,0,4'hE,4'h8,2'b11,0,0,0,0, 1,0,0,0,0, 4'h4,16'd2,16'd1};
    vecs[4]  = '{1,0,4'hA,4'h0,2'b00,1,0,0,0, 0,0,0,0,0, 4'h8,16'd3,16'd1};
    vecs[5]  = '{1,0,4'hB,4'h0,2'b00,1,0,0,0, 1,1,0,0,0, 4'h8,16'd3,16'd2};
    vecs[6]  = '{1,0,4'hC,4'h0,2'b00,1,0,0,0, 0,0,0,0,0, 4'h8,16'd4,16'd2};
    vecs[7]  = '{1,0,4'hD,4'h0,2'b00,1,0,0,0, 1,1,0,0,0, 4'h8,16'd4,16'd3};
    vecs[8]  = '{1,0,4'hF,4'h0,2'b00,1,0,0,0, 0,0,0,0,0, 4'h8,16'd5,16'd3};
    vecs[9]  = '{1,0,4'hE,4'h7,2'b01,0,0,0,0, 1,0,0,0,0, 4'h8,16'd5,16'd4};
    vecs[10] = '{1,0,4'h8,4'h0,2'b00,0,1,0,0, 1,0,1,0,0, 4'hB,16'd6,16'd4};
    vecs[11] = '{1,0,4'h6,4'h4,2'b10,0,0,0,0, 1,0,0,0,0, 4'hB,16'd7,16'd4};
    vecs[12] = '{1,1,4'hE,4'h0,2'b11,1,1,1,0, 0,0,0,0,0, 4'h7,16'd8,16'd4};
    vecs[13] = '{0,0,4'hE,4'h0,2'b11,1,0,1,0, 0,0,0,0,0, 4'h7,16'd8,16'd4};
    vecs[14] = '{1,0,4'h9,4'h0,2'b00,1,0,0,0, 1,1,0,0,0, 4'h7,16'd8,16'd4};
    vecs[15] = '{1,0,4'h3,4'h8,2'b11,1,0,0,0, 0,0,0,0,0, 4'h7,16'd9,16'd4};
    vecs[16] = '{1,0,4'h4,4'h0,2'b00,1,0,0,0, 0,0,0,0,0, 4'h7,16'd9,16'd5};

    // Reset held with a live-looking AL write: nothing may be gated through.
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_reg_write", {15'd0, reg_write}, 16'd0);
    chk("reset_cond_ex", {15'd0, cond_ex}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_flags", {12'd0, flags}, 16'h0000);
    chk("rst_exec", exec_cnt, 16'd0);
    chk("rst_skip", skip_cnt, 16'd0);
    chk("rst_annul", {15'd0, annul}, 16'd0);
    next_cycle();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].valid, vecs[i].stall, vecs[i].cond, vecs[i].alu, vecs[i].fw,
            vecs[i].rw, vecs[i].mw, vecs[i].ps, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("v%0d_cond_ex", i), {15'd0, cond_ex}, {15'd0, vecs[i].e_cx});
      chk($sformatf("v%0d_reg_write", i), {15'd0, reg_write}, {15'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_mem_write", i), {15'd0, mem_write}, {15'd0, vecs[i].e_mw});
      chk($sformatf("v%0d_pc_src", i), {15'd0, pc_src}, {15'd0, vecs[i].e_ps});
      chk($sformatf("v%0d_flush_fd", i), {15'd0, flush_fd}, {15'd0, vecs[i].e_ps});
      chk($sformatf("v%0d_annul", i), {15'd0, annul}, {15'd0, vecs[i].e_annul});
      chk($sformatf("v%0d_flags", i), {12'd0, flags}, {12'd0, vecs[i].e_flags});
      chk($sformatf("v%0d_exec", i), exec_cnt, vecs[i].e_exec);
      chk($sformatf("v%0d_skip", i), skip_cnt, vecs[i].e_skip);
      next_cycle();
    end

    // Taken branch at N; N+1 and N+2 annulled (pc_src_e forced off inside window).
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("br_pc_src", {15'd0, pc_src}, 16'd1);
    chk("br_flush", {15'd0, flush_fd}, 16'd1);
    chk("br_annul_n", {15'd0, annul}, 16'd0);
    next_cycle();
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("br_n%0d_annul", k), {15'd0, annul}, 16'd1);
      chk($sformatf("br_n%0d_reg_write", k), {15'd0, reg_write}, 16'd0);
      chk($sformatf("br_n%0d_pc_src", k), {15'd0, pc_src}, 16'd0);
      chk($sformatf("br_n%0d_flush", k), {15'd0, flush_fd}, 16'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("br_n3_annul", {15'd0, annul}, 16'd0);
    chk("br_n3_reg_write", {15'd0, reg_write}, 16'd1);
    chk("br_n3_exec", exec_cnt, 16'd10);
    chk("br_n3_skip", skip_cnt, 16'd6);
    next_cycle();

    // Branch again, stall at N+1 stretches the window to N+3.
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("st_pc_src", {15'd0, pc_src}, 16'd1);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, (k == 1), 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("st_n%0d_annul", k), {15'd0, annul}, 16'd1);
      chk($sformatf("st_n%0d_reg_write", k), {15'd0, reg_write}, 16'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("st_n4_annul", {15'd0, annul}, 16'd0);
    chk("st_n4_reg_write", {15'd0, reg_write}, 16'd1);
    chk("st_n4_exec", exec_cnt, 16'd12);
    next_cycle();

    // Asynchronous reset in the middle of an annul window.
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_annul_before", {15'd0, annul}, 16'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_annul_after", {15'd0, annul}, 16'd0);
    chk("mid_flags", {12'd0, flags}, 16'h0000);
    chk("mid_exec", exec_cnt, 16'd0);
    chk("mid_reg_write", {15'd0, reg_write}, 16'd0);
    next_cycle();
    reset = 1'b0;

    // Count up to 16'hFFFE from zero, then saturate and clear.
    drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", exec_cnt, 16'hFFFE);
    next_cycle();
    chk("sat_hit", exec_cnt, 16'hFFFF);
    next_cycle();
    chk("sat_hold", exec_cnt, 16'hFFFF);
    chk("sat_skip", skip_cnt, 16'd0);
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_cond_ex", {15'd0, cond_ex}, 16'd1);
    next_cycle();
    chk("clr_exec", exec_cnt, 16'd0);
    idle();
    next_cycle();
    chk("clr_exec_idle", exec_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
